// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-synchronous
// value commit, per-slot blanking and optional leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  lz_en,
  output logic                  load_ack,
  output logic                  pending,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {OFF = 1'b0, SCAN = 1'b1} state_t;

  logic [CW-1:0]          cnt_r;
  logic [IW-1:0]          idx_r;
  logic [4*DIGITS-1:0]    shadow_r;
  logic [4*DIGITS-1:0]    active_r;
  logic                   pending_r;
  logic                   load_ack_r;
  state_t                 state_r;
  state_t                 state_next_s;
  logic [DIGITS-1:0]      an_r;
  logic [6:0]             seg_r;

  logic                   last_cnt_s;
  logic                   last_idx_s;
  logic                   boundary_s;
  logic                   commit_s;
  logic [3:0]             digit_s;
  logic [DIGITS-1:0]      zero_run_s;
  logic                   run_s;
  logic [DIGITS-1:0]      an_s;
  logic [6:0]             seg_s;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank the segments.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign last_cnt_s = (cnt_r == CW'(DIV - 1));
  assign last_idx_s = (idx_r == IW'(DIGITS - 1));
  assign boundary_s = last_cnt_s && last_idx_s;
  assign commit_s   = boundary_s && pending_r;

  // OFF leaves only through the first commit; SCAN is held until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      OFF: begin
        if (commit_s) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = OFF;
        end
      end
      SCAN:    state_next_s = SCAN;
      default: state_next_s = OFF;
    endcase
  end

  // Digit select, leading-zero run (from the top digit down) and slot drive.
  always_comb begin
    digit_s    = 4'd0;
    zero_run_s = '0;
    run_s      = 1'b1;
    an_s       = {DIGITS{1'b1}};
    seg_s      = 7'h7F;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_s         = run_s && (active_r[4*i +: 4] == 4'd0);
      zero_run_s[i] = run_s;
      if (idx_r == IW'(i)) begin
        digit_s = active_r[4*i +: 4];
      end else begin
        digit_s = digit_s;
      end
    end
    if ((state_r == OFF) || (cnt_r == CW'(0))) begin
      an_s  = {DIGITS{1'b1}};
      seg_s = 7'h7F;
    end else begin
      an_s = ~(DIGITS'(1) << idx_r);
      if (lz_en && (idx_r != IW'(0)) && zero_run_s[idx_r]) begin
        seg_s = 7'h7F;
      end else begin
        seg_s = bcd_to_seg(digit_s);
      end
    end
  end

  // Prescaler, digit index, shadow/active commit and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= CW'(0);
      idx_r      <= IW'(0);
      shadow_r   <= '0;
      active_r   <= '0;
      pending_r  <= 1'b0;
      load_ack_r <= 1'b0;
      state_r    <= OFF;
      an_r       <= {DIGITS{1'b1}};
      seg_r      <= 7'h7F;
    end else begin
      cnt_r <= last_cnt_s ? CW'(0) : cnt_r + CW'(1);
      if (last_cnt_s) begin
        idx_r <= last_idx_s ? IW'(0) : idx_r + IW'(1);
      end
      // The commit samples the pre-edge shadow, so a coincident load waits a frame.
      if (commit_s) begin
        active_r <= shadow_r;
      end
      if (load) begin
        shadow_r  <= data_in;
        pending_r <= 1'b1;
      end else if (boundary_s) begin
        pending_r <= 1'b0;
      end
      load_ack_r <= load;
      state_r    <= state_next_s;
      an_r       <= an_s;
      seg_r      <= seg_s;
    end
  end

  assign load_ack = load_ack_r;
  assign pending  = pending_r;
  assign an       = an_r;
  assign seg      = seg_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (DIGITS=4, DIV=4): a cycle model pushes
// expected outputs per clock, plus directed per-digit frame checks.
module tb_seg7_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        lz_en;
  logic        load_ack;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .lz_en(lz_en),
    .load_ack(load_ack), .pending(pending), .an(an), .seg(seg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ack;
    logic       pend;
  } exp_t;

  exp_t sb_q[$];

  int          m_cnt, m_idx;
  logic [15:0] m_sh, m_act;
  logic        m_pend, m_valid;

  function automatic logic [6:0] m_dec(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return t[d];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_sh = 16'h0; m_act = 16'h0;
    m_pend = 1'b0; m_valid = 1'b0;
    sb_q.delete();
  endtask

  // One clock: predict the registered outputs, advance the model, compare.
  task automatic step();
    exp_t       e;
    exp_t       got;
    logic [3:0] dg;
    logic       z;
    logic       bnd;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    if (m_valid && m_cnt != 0) begin
      e.an = ~(4'b0001 << m_idx);
      dg   = m_act[4*m_idx +: 4];
      z    = 1'b1;
      for (int k = m_idx; k < DIGITS; k++) if (m_act[4*k +: 4] != 4'h0) z = 1'b0;
      e.seg = (lz_en && m_idx > 0 && z) ? 7'h7F : m_dec(dg);
    end
    e.ack = load;
    bnd = (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
    if (bnd && m_pend) begin
      m_act   = m_sh;
      m_valid = 1'b1;
    end
    if (load) begin
      m_sh   = data_in;
      m_pend = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0;
    end
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    got = sb_q.pop_front();
    check_val("an", 32'(an), 32'(got.an));
    check_val("seg", 32'(seg), 32'(got.seg));
    check_val("load_ack", 32'(load_ack), 32'(got.ack));
    check_val("pending", 32'(pending), 32'(got.pend));
  endtask

  task automatic do_load(input logic [15:0] v);
    data_in = v;
    load    = 1'b1;
    step();
    check_val("ack_pulse", 32'(load_ack), 32'd1);
  endtask

  task automatic run_to_commit();
    int n = 0;
    while (m_pend && n < 40) begin
      step();
      n++;
    end
    check_val("commit_reached", 32'(pending), 32'd0);
  endtask

  // Sixteen output cycles: every digit gets exactly three drive cycles of its value.
  task automatic check_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] exp_seg [4];
    int         drives [4];
    int         d;
    exp_seg = '{s0, s1, s2, s3};
    drives  = '{0, 0, 0, 0};
    for (int c = 0; c < DIGITS * DIV; c++) begin
      step();
      d = -1;
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d >= 0) begin
        check_val(tag, 32'(seg), 32'(exp_seg[d]));
        drives[d]++;
      end
    end
    for (int i = 0; i < DIGITS; i++) check_val({tag, "_drives"}, 32'(drives[i]), 32'd3);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 16'h0; lz_en = 1'b0;
    model_reset();
    #1;
    check_val("rst_an", 32'(an), 32'hF);
    check_val("rst_seg", 32'(seg), 32'h7F);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_ack", 32'(load_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: no load keeps the display off
    for (int c = 0; c < 40; c++) step();
    check_val("off_an", 32'(an), 32'hF);

    // 2: 1234
    do_load(16'h1234);
    check_val("pending_set", 32'(pending), 32'd1);
    run_to_commit();
    check_frame("f1234", 7'h79, 7'h24, 7'h30, 7'h19);

    // 3: leading-zero suppression on, then off
    lz_en = 1'b1;
    do_load(16'h0007);
    run_to_commit();
    check_frame("lz_on", 7'h7F, 7'h7F, 7'h7F, 7'h78);
    lz_en = 1'b0;
    step();
    check_frame("lz_off", 7'h40, 7'h40, 7'h40, 7'h78);

    // 4: load landing exactly on the boundary cycle waits one frame
    do_load(16'h5555);
    for (int c = 0; c < 20 && !((m_cnt == DIV - 1) && (m_idx == DIGITS - 1)); c++) step();
    do_load(16'h9999);
    check_val("bnd_pending", 32'(pending), 32'd1);
    check_frame("f5555", 7'h12, 7'h12, 7'h12, 7'h12);
    run_to_commit();
    check_frame("f9999", 7'h10, 7'h10, 7'h10, 7'h10);

    // 5: non-BCD digits blank segments but keep their anode
    do_load(16'hFA98);
    run_to_commit();
    check_frame("fFA98", 7'h7F, 7'h7F, 7'h10, 7'h00);

    // 6: asynchronous reset mid-slot with a load pending
    do_load(16'h4321);
    step();
    check_val("pend_before_rst", 32'(pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_an", 32'(an), 32'hF);
    check_val("arst_seg", 32'(seg), 32'h7F);
    check_val("arst_pending", 32'(pending), 32'd0);
    check_val("arst_ack", 32'(load_ack), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) step();
    check_val("post_rst_off", 32'(an), 32'hF);
    do_load(16'h0042);
    run_to_commit();
    check_frame("f0042", 7'h40, 7'h40, 7'h19, 7'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
